mux_lut_unit: RTL

MUX_LUT_UNIT -- requirements
Module: mux_lut_unit

---
 rtl/mux_lut_pkg.sv | 7 +
 rtl/mux_lut_cell.sv | 20 ++
 rtl/mux_lut_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_lut_pkg.sv
// mux_lut_pkg: shared FSM state type and truth-table sizing for mux_lut_unit
package mux_lut_pkg;
  typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_e;
  function automatic int tbl_size(input int k);
    return 1 << k;
  endfunction
endpackage

// File: rtl/mux_lut_cell.sv
// mux_lut_cell: one lane of the LUT, a K-level binary tree of 2:1 muxes over the table bits
module mux_lut_cell import mux_lut_pkg::*; #(
  parameter int K = 2
) (
  input  logic [tbl_size(K)-1:0] tbl,
  input  logic [K-1:0]           sel,
  output logic                   y
);
  localparam int N = tbl_size(K);
  // Heap-ordered tree: node i has children 2i and 2i+1, leaves N..2N-1 hold table bits.
  // The root level selects on the most significant operand, so leaf N+n is reached by pattern n.
  logic [2*N-1:1] t;
  assign t[2*N-1:N] = tbl;
  for (genvar d = 0; d < K; d++) begin : g_lvl
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      assign t[(1 << d) + j] = sel[K-1-d] ? t[2*((1 << d) + j) + 1] : t[2*((1 << d) + j)];
    end
  end
  assign y = t[1];
endmodule

// File: rtl/mux_lut_unit.sv
// mux_lut_unit: bitwise K-input LUT with loadable truth table and valid/ready streaming
// Optional op_count output enabled by defining MUX_LUT_UNIT_OPCNT_EN.
module mux_lut_unit import mux_lut_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int K     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  input  logic [tbl_size(K)-1:0]    cfg_table,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  input  logic [K*WIDTH-1:0]        in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic                      configured
`ifdef MUX_LUT_UNIT_OPCNT_EN
  , output logic [15:0]             op_count
`endif
);
  localparam int N = tbl_size(K);
  state_e state_q, state_d;
  logic [N-1:0] tbl_q, tbl_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic configured_q, configured_d;
  logic load, push, pop;
  logic [WIDTH-1:0] res;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [K-1:0] sel;
    for (genvar j = 0; j < K; j++) begin : g_op
      assign sel[j] = in_data[j*WIDTH + i];
    end
    mux_lut_cell #(.K(K)) u_cell (.tbl(tbl_q), .sel(sel), .y(res[i]));
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= UNCFG;
    else state_q <= state_d;
  // Next state: DRAIN waits for the held result to leave before a load, or falls back if the request drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNCFG:   state_d = cfg_valid ? RUN : UNCFG;
      RUN:     state_d = (cfg_valid && out_valid_q) ? DRAIN : RUN;
      DRAIN:   state_d = (!cfg_valid || !out_valid_q) ? RUN : DRAIN;
      default: state_d = UNCFG;
    endcase
  end
  // Handshake outputs: a pending config request always blocks operand intake
  always_comb begin
    cfg_ready = (state_q == UNCFG) || !out_valid_q;
    in_ready  = (state_q == RUN) && !cfg_valid && (!out_valid_q || out_ready);
    load      = cfg_valid && cfg_ready;
    push      = in_valid && in_ready;
    pop       = out_valid_q && out_ready;
  end
  // Datapath next state; load and push never coincide so beats always see a stable table
  always_comb begin
    tbl_d        = load ? cfg_table : tbl_q;
    configured_d = configured_q || load;
    out_valid_d  = push ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    out_data_d   = push ? res : out_data_q;
  end
  // Datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tbl_q        <= '0;
      configured_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      tbl_q        <= tbl_d;
      configured_q <= configured_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign configured = configured_q;
`ifdef MUX_LUT_UNIT_OPCNT_EN
  logic [15:0] cnt_q, cnt_d;
  // Consumed-result counter, saturating, restarted by every table load
  always_comb cnt_d = load ? 16'h0 : ((pop && cnt_q != 16'hFFFF) ? cnt_q + 16'h1 : cnt_q);
  // Counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 16'h0;
    else cnt_q <= cnt_d;
  assign op_count = cnt_q;
`endif
endmodule
